// File: rtl/computedram_pkg.sv
// Shared definitions for the ComputeDRAM command arbiter: controller states
// and default row/timing field widths.
package computedram_pkg;

  localparam int ROW_W_DEF = 10;
  localparam int TIM_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/computedram_rr_arb.sv
// Two-way round-robin grant: with both requesters valid the one that did not
// win last time is chosen; a lone requester always wins.
module computedram_rr_arb (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt_vld,
  output logic gnt_id
);

  always_comb begin
    gnt_vld = valid0 | valid1;
    gnt_id  = 1'b0;
    if (valid0 && valid1) begin
      gnt_id = ~last_grant;
    end else begin
      gnt_id = valid1;
    end
  end

endmodule

// File: rtl/computedram_arb.sv
// ComputeDRAM command arbiter: round-robin between two requesters, issues one
// registered row-pair command at a time, then idles GAP_CYCLES cycles.
// Optional statistics counters are enabled with `define COMPUTEDRAM_ARB_STATS_EN.
module computedram_arb
  import computedram_pkg::*;
#(
  parameter int ROW_W      = ROW_W_DEF,
  parameter int TIM_W      = TIM_W_DEF,
  parameter int GAP_CYCLES = 4
) (
  input  logic             user_clk,
  input  logic             user_rst,
  input  logic             init_done,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [ROW_W-1:0] s0_r1,
  input  logic [ROW_W-1:0] s0_r2,
  input  logic [TIM_W-1:0] s0_t1,
  input  logic [TIM_W-1:0] s0_t2,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [ROW_W-1:0] s1_r1,
  input  logic [ROW_W-1:0] s1_r2,
  input  logic [TIM_W-1:0] s1_t1,
  input  logic [TIM_W-1:0] s1_t2,
  output logic [ROW_W-1:0] ComputeDRAM_R1,
  output logic [ROW_W-1:0] ComputeDRAM_R2,
  output logic [TIM_W-1:0] ComputeDRAM_T1,
  output logic [TIM_W-1:0] ComputeDRAM_T2,
  output logic             ComputeDRAM_vld,
  input  logic             ComputeDRAM_rdy,
  output logic             grant_id,
  output logic             busy,
  output logic             cmd_err
`ifdef COMPUTEDRAM_ARB_STATS_EN
  ,
  output logic [15:0]      stat_issued0,
  output logic [15:0]      stat_issued1,
  output logic [15:0]      stat_err
`endif
);

  // GAP_CYCLES = 0 still needs a legal one-bit counter even though it is never loaded
  localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : CNT_W'(0);

  state_e           state;
  logic             last_grant;
  logic [CNT_W-1:0] gap_cnt;
  logic             gnt_vld;
  logic             gnt_id;
  logic             arb_en;
  logic             accept;
  logic             same_row;
  logic             handshake;
  logic [ROW_W-1:0] win_r1;
  logic [ROW_W-1:0] win_r2;
  logic [TIM_W-1:0] win_t1;
  logic [TIM_W-1:0] win_t2;

  computedram_rr_arb u_rr_arb (
    .valid0     (s0_valid),
    .valid1     (s1_valid),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .gnt_id     (gnt_id)
  );

  assign arb_en    = (state == IDLE) && init_done;
  assign accept    = arb_en && gnt_vld;
  assign s0_ready  = accept && !gnt_id;
  assign s1_ready  = accept && gnt_id;

  assign win_r1    = gnt_id ? s1_r1 : s0_r1;
  assign win_r2    = gnt_id ? s1_r2 : s0_r2;
  assign win_t1    = gnt_id ? s1_t1 : s0_t1;
  assign win_t2    = gnt_id ? s1_t2 : s0_t2;
  assign same_row  = (win_r1 == win_r2);

  assign handshake       = (state == ISSUE) && ComputeDRAM_rdy;
  assign ComputeDRAM_vld = (state == ISSUE);
  assign busy            = (state != IDLE);

  // Stage boundary: accept -> ISSUE register, ISSUE -> GAP countdown
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      grant_id       <= 1'b0;
      gap_cnt        <= '0;
      cmd_err        <= 1'b0;
      ComputeDRAM_R1 <= '0;
      ComputeDRAM_R2 <= '0;
      ComputeDRAM_T1 <= '0;
      ComputeDRAM_T2 <= '0;
    end else begin
      cmd_err <= accept && same_row;
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= gnt_id;
            if (!same_row) begin
              ComputeDRAM_R1 <= win_r1;
              ComputeDRAM_R2 <= win_r2;
              ComputeDRAM_T1 <= win_t1;
              ComputeDRAM_T2 <= win_t2;
              grant_id       <= gnt_id;
              state          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (handshake) begin
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COMPUTEDRAM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      stat_issued0 <= '0;
      stat_issued1 <= '0;
      stat_err     <= '0;
    end else begin
      if (handshake && !grant_id) stat_issued0 <= sat_inc(stat_issued0);
      if (handshake && grant_id)  stat_issued1 <= sat_inc(stat_issued1);
      if (accept && same_row)     stat_err     <= sat_inc(stat_err);
    end
  end
`endif

endmodule

// File: tb/tb_computedram_arb.sv
// Directed bench for computedram_arb: cycle table for arbitration/gap timing
// plus hand sequences for init gating, back-pressure, dropped commands and reset.
module tb_computedram_arb;

  logic       user_clk;
  logic       user_rst;
  logic       init_done;
  logic       s0_valid, s1_valid;
  logic       s0_ready, s1_ready;
  logic [9:0] s0_r1, s0_r2, s1_r1, s1_r2;
  logic [3:0] s0_t1, s0_t2, s1_t1, s1_t2;
  logic [9:0] R1, R2;
  logic [3:0] T1, T2;
  logic       vld, rdy;
  logic       grant_id, busy, cmd_err;
`ifdef COMPUTEDRAM_ARB_STATS_EN
  logic [15:0] stat_issued0, stat_issued1, stat_err;
`endif

  int checks;
  int failures;

  computedram_arb #(.ROW_W(10), .TIM_W(4), .GAP_CYCLES(4)) dut (
    .user_clk        (user_clk),
    .user_rst        (user_rst),
    .init_done       (init_done),
    .s0_valid        (s0_valid),
    .s0_ready        (s0_ready),
    .s0_r1           (s0_r1),
    .s0_r2           (s0_r2),
    .s0_t1           (s0_t1),
    .s0_t2           (s0_t2),
    .s1_valid        (s1_valid),
    .s1_ready        (s1_ready),
    .s1_r1           (s1_r1),
    .s1_r2           (s1_r2),
    .s1_t1           (s1_t1),
    .s1_t2           (s1_t2),
    .ComputeDRAM_R1  (R1),
    .ComputeDRAM_R2  (R2),
    .ComputeDRAM_T1  (T1),
    .ComputeDRAM_T2  (T2),
    .ComputeDRAM_vld (vld),
    .ComputeDRAM_rdy (rdy),
    .grant_id        (grant_id),
    .busy            (busy),
    .cmd_err         (cmd_err)
`ifdef COMPUTEDRAM_ARB_STATS_EN
    ,
    .stat_issued0    (stat_issued0),
    .stat_issued1    (stat_issued1),
    .stat_err        (stat_err)
`endif
  );

  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  typedef struct {
    logic       init;
    logic       v0;
    logic       v1;
    logic       rdy;
    logic       e_r0;
    logic       e_r1;
    logic       e_vld;
    logic       e_busy;
    logic       e_gid;
    logic [9:0] e_R1;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge user_clk);
    #1;
  endtask

  task automatic do_reset();
    user_rst  = 1'b1;
    init_done = 1'b0;
    s0_valid  = 1'b0;
    s1_valid  = 1'b0;
    rdy       = 1'b0;
    s0_r1 = 10'd4; s0_r2 = 10'd5; s0_t1 = 4'd2; s0_t2 = 4'd2;
    s1_r1 = 10'd7; s1_r2 = 10'd3; s1_t1 = 4'd1; s1_t2 = 4'd3;
    next_cycle();
    next_cycle();
    user_rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd4};
    for (int i = 2; i <= 5; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd4};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd4};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd7};
    for (int i = 8; i <= 11; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd7};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd7};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd4};

    // Reset values
    do_reset();
    #3;
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    chk("rst_R1", 32'(R1), 32'd0);
    chk("rst_R2", 32'(R2), 32'd0);
    chk("rst_T1", 32'(T1), 32'd0);
    chk("rst_T2", 32'(T2), 32'd0);
    next_cycle();

    // Arbitration, issue latency, gap length and round-robin alternation
    for (int i = 0; i < 14; i++) begin
      init_done = tbl[i].init;
      s0_valid  = tbl[i].v0;
      s1_valid  = tbl[i].v1;
      rdy       = tbl[i].rdy;
      #3;
      chk($sformatf("row%0d_s0_ready", i), 32'(s0_ready), 32'(tbl[i].e_r0));
      chk($sformatf("row%0d_s1_ready", i), 32'(s1_ready), 32'(tbl[i].e_r1));
      chk($sformatf("row%0d_vld", i),      32'(vld),      32'(tbl[i].e_vld));
      chk($sformatf("row%0d_busy", i),     32'(busy),     32'(tbl[i].e_busy));
      chk($sformatf("row%0d_gid", i),      32'(grant_id), 32'(tbl[i].e_gid));
      chk($sformatf("row%0d_R1", i),       32'(R1),       32'(tbl[i].e_R1));
      next_cycle();
    end

    // init_done low blocks arbitration
    do_reset();
    s0_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #3;
      chk($sformatf("noinit%0d_s0_ready", i), 32'(s0_ready), 32'd0);
      chk($sformatf("noinit%0d_vld", i), 32'(vld), 32'd0);
      next_cycle();
    end
    init_done = 1'b1;
    #3;
    chk("init_s0_ready", 32'(s0_ready), 32'd1);
    next_cycle();

    // Back-pressure for 7 cycles, init_done dropping mid-flight
    s0_valid  = 1'b0;
    init_done = 1'b0;
    rdy       = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #3;
      chk($sformatf("hold%0d_vld", i), 32'(vld), 32'd1);
      chk($sformatf("hold%0d_R1", i), 32'(R1), 32'd4);
      chk($sformatf("hold%0d_R2", i), 32'(R2), 32'd5);
      chk($sformatf("hold%0d_T1", i), 32'(T1), 32'd2);
      chk($sformatf("hold%0d_T2", i), 32'(T2), 32'd2);
      next_cycle();
    end
    rdy = 1'b1;
    #3;
    chk("hs_vld", 32'(vld), 32'd1);
    next_cycle();
    rdy = 1'b0;
    #3;
    chk("gap_vld", 32'(vld), 32'd0);
    chk("gap_busy", 32'(busy), 32'd1);
    chk("gap_R1_kept", 32'(R1), 32'd4);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      #3;
      chk($sformatf("gap%0d_busy", i), 32'(busy), 32'd1);
      next_cycle();
    end

    // Equal rows: accepted then dropped with an error pulse
    init_done = 1'b1;
    s1_valid  = 1'b1;
    s1_r1     = 10'd9;
    s1_r2     = 10'd9;
    #3;
    chk("err_s1_ready", 32'(s1_ready), 32'd1);
    chk("err_busy_before", 32'(busy), 32'd0);
    next_cycle();
    s1_valid = 1'b0;
    #3;
    chk("err_pulse", 32'(cmd_err), 32'd1);
    chk("err_vld", 32'(vld), 32'd0);
    chk("err_busy", 32'(busy), 32'd0);
`ifdef COMPUTEDRAM_ARB_STATS_EN
    chk("err_stat", 32'(stat_err), 32'd1);
`endif
    next_cycle();
    #3;
    chk("err_pulse_end", 32'(cmd_err), 32'd0);
    chk("err_vld_after", 32'(vld), 32'd0);
    next_cycle();

    // Reset during ISSUE
    s0_valid = 1'b1;
    rdy      = 1'b0;
    next_cycle();
    s0_valid = 1'b0;
    #3;
    chk("pre_rst_vld", 32'(vld), 32'd1);
    #1;
    user_rst = 1'b1;
    #1;
    chk("async_rst_vld", 32'(vld), 32'd0);
    chk("async_rst_R1", 32'(R1), 32'd0);
    chk("async_rst_T2", 32'(T2), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    next_cycle();
    user_rst = 1'b0;
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    s1_r1    = 10'd7;
    s1_r2    = 10'd3;
    #3;
    chk("post_rst_s0_ready", 32'(s0_ready), 32'd1);
    chk("post_rst_s1_ready", 32'(s1_ready), 32'd0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
